// File: rtl/ball_obj.sv
// Basketball sprite: projectile trajectory stepped once per frame, plus an 8x8 round ball
// rendered combinationally for the current pixel.
module ball_obj #(
  parameter int          H_MAX       = 640,
  parameter int          X_START     = 100,
  parameter int          Y_START     = 400,
  parameter int          FLOOR_Y     = 472,
  parameter int          GRAVITY     = 1,
  parameter int          HOLD_FRAMES = 60,
  parameter logic [11:0] BALL_RGB    = 12'hF80
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              refr_tick,
  input  logic              shoot,
  input  logic signed [7:0] vx_init,
  input  logic signed [7:0] vy_init,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  output logic              ball_on,
  output logic [11:0]       ball_rgb,
  output logic              in_flight,
  output logic              landed
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);

  localparam logic signed [10:0] X_START_S = 11'(X_START);
  localparam logic signed [10:0] Y_START_S = 11'(Y_START);
  localparam logic signed [10:0] X_MAX_S   = 11'(H_MAX - 8);
  localparam logic signed [10:0] Y_REST_S  = 11'(FLOOR_Y - 8);
  localparam logic signed [11:0] FLOOR_S   = 12'(FLOOR_Y);
  localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLIGHT = 2'd1,
    S_LANDED = 2'd2
  } state_t;

  state_t                r_state;
  logic signed [10:0]    r_x;
  logic signed [10:0]    r_y;
  logic signed [7:0]     r_vx;
  logic signed [7:0]     r_vy;
  logic [HW-1:0]         r_hold;
  logic                  r_in_flight;
  logic                  r_landed;

  function automatic logic signed [10:0] sext8(input logic signed [7:0] v);
    return $signed({{3{v[7]}}, v});
  endfunction

  // Gravity step on vy, saturating at the 8-bit signed limits.
  function automatic logic signed [7:0] sat_vy(input logic signed [7:0] v);
    logic signed [8:0] s;
    logic signed [8:0] g;
    g = 9'(GRAVITY);
    s = $signed({v[7], v}) + g;
    if (s > 9'sd127)
      return 8'sd127;
    else if (s < -9'sd128)
      return -8'sd128;
    else
      return s[7:0];
  endfunction

  function automatic logic [7:0] rom_row(input logic [2:0] r);
    case (r)
      3'd0:    return 8'h3C;
      3'd1:    return 8'h7E;
      3'd6:    return 8'h7E;
      3'd7:    return 8'h3C;
      default: return 8'hFF;
    endcase
  endfunction

  logic signed [10:0] w_x_next;
  logic signed [10:0] w_y_next;
  logic signed [11:0] w_y_bot;
  logic               w_hit_floor;
  logic               w_hit_left;
  logic               w_hit_right;

  assign w_x_next    = r_x + sext8(r_vx);
  assign w_y_next    = r_y + sext8(r_vy);
  assign w_y_bot     = $signed({w_y_next[10], w_y_next}) + 12'sd7;
  assign w_hit_floor = (w_y_bot >= FLOOR_S);
  assign w_hit_left  = (w_x_next < 11'sd0);
  assign w_hit_right = (w_x_next > X_MAX_S);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_x         <= X_START_S;
      r_y         <= Y_START_S;
      r_vx        <= 8'sd0;
      r_vy        <= 8'sd0;
      r_hold      <= '0;
      r_in_flight <= 1'b0;
      r_landed    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (shoot) begin
            r_vx        <= vx_init;
            r_vy        <= vy_init;
            r_state     <= S_FLIGHT;
            r_in_flight <= 1'b1;
          end
        end
        S_FLIGHT: begin
          if (refr_tick) begin
            r_vy <= sat_vy(r_vy);
            r_x  <= w_x_next;
            r_y  <= w_y_next;
            if (w_hit_floor)
              r_y <= Y_REST_S;
            if (w_hit_left)
              r_x <= 11'sd0;
            else if (w_hit_right)
              r_x <= X_MAX_S;
            if (w_hit_floor || w_hit_left || w_hit_right) begin
              r_state     <= S_LANDED;
              r_hold      <= '0;
              r_in_flight <= 1'b0;
              r_landed    <= 1'b1;
            end
          end
        end
        S_LANDED: begin
          if (refr_tick) begin
            if (r_hold == HOLD_LAST) begin
              r_state  <= S_IDLE;
              r_x      <= X_START_S;
              r_y      <= Y_START_S;
              r_vx     <= 8'sd0;
              r_vy     <= 8'sd0;
              r_hold   <= '0;
              r_landed <= 1'b0;
            end else begin
              r_hold <= r_hold + HW'(1);
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_flight <= 1'b0;
          r_landed    <= 1'b0;
        end
      endcase
    end
  end

  // Rendering: signed box test in 12 bits so x+7 and negative y never wrap.
  logic signed [11:0] w_px;
  logic signed [11:0] w_py;
  logic signed [11:0] w_bx;
  logic signed [11:0] w_by;
  logic               w_in_x;
  logic               w_in_y;
  logic [2:0]         w_col;
  logic [2:0]         w_row;
  logic [7:0]         w_bits;

  assign w_px   = $signed({2'b00, pixel_x});
  assign w_py   = $signed({2'b00, pixel_y});
  assign w_bx   = $signed({r_x[10], r_x});
  assign w_by   = $signed({r_y[10], r_y});
  assign w_in_x = (w_px >= w_bx) && (w_px <= w_bx + 12'sd7);
  assign w_in_y = (w_py >= w_by) && (w_py <= w_by + 12'sd7);
  assign w_col  = pixel_x[2:0] - r_x[2:0];
  assign w_row  = pixel_y[2:0] - r_y[2:0];
  assign w_bits = rom_row(w_row);

  assign ball_on   = w_in_x && w_in_y && w_bits[~w_col];
  assign ball_rgb  = BALL_RGB;
  assign in_flight = r_in_flight;
  assign landed    = r_landed;

endmodule

// File: tb/tb_ball_obj.sv
// Scoreboard bench for ball_obj: directed shots, position observed through pixel probes.
module tb_ball_obj;

  logic              clk = 1'b0;
  logic              reset;
  logic              refr_tick;
  logic              shoot;
  logic signed [7:0] vx_init;
  logic signed [7:0] vy_init;
  logic [9:0]        pixel_x;
  logic [9:0]        pixel_y;
  logic              ball_on;
  logic [11:0]       ball_rgb;
  logic              in_flight;
  logic              landed;

  logic              probe_vld;
  logic [2:0]        exp_q[$];
  string             name_q[$];
  int                n_pass  = 0;
  int                n_total = 0;

  logic [7:0] rom_tb [8] = '{8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7E, 8'h3C};

  ball_obj dut (
    .clk       (clk),
    .reset     (reset),
    .refr_tick (refr_tick),
    .shoot     (shoot),
    .vx_init   (vx_init),
    .vy_init   (vy_init),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .ball_on   (ball_on),
    .ball_rgb  (ball_rgb),
    .in_flight (in_flight),
    .landed    (landed)
  );

  always #5 clk = ~clk;

  // Monitor: whenever a probe is presented, pop its expectation and compare.
  always @(negedge clk) begin
    if (probe_vld) begin
      logic [2:0] e;
      logic [2:0] got;
      string      nm;
      n_total++;
      got = {ball_on, in_flight, landed};
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_empty: got on/fl/ld=%b, no expectation queued", got);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (got === e && ball_rgb === 12'hF80)
          n_pass++;
        else
          $display("FAIL %s: got on/fl/ld=%b rgb=%h, want %b rgb=f80 (px=%0d py=%0d)",
                   nm, got, ball_rgb, e, pixel_x, pixel_y);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    refr_tick = 1'b1;
    step();
    refr_tick = 1'b0;
  endtask

  task automatic probe(input int px, input int py, input logic on, input logic fl,
                       input logic ld, input string nm);
    pixel_x = 10'(px);
    pixel_y = 10'(py);
    exp_q.push_back({on, fl, ld});
    name_q.push_back(nm);
    probe_vld = 1'b1;
    step();
    probe_vld = 1'b0;
  endtask

  // Pins the ball's top-left corner at (x,y) and checks the state flags.
  task automatic check_pos(input int x, input int y, input logic fl, input logic ld,
                           input string tag);
    probe(x + 3, y,     1'b1, fl, ld, {tag, "_top"});
    probe(x,     y + 3, 1'b1, fl, ld, {tag, "_left"});
    probe(x + 8, y + 3, 1'b0, fl, ld, {tag, "_right_out"});
    probe(x + 3, y + 8, 1'b0, fl, ld, {tag, "_below_out"});
    if (x > 0) probe(x - 1, y + 3, 1'b0, fl, ld, {tag, "_left_out"});
    if (y > 0) probe(x + 3, y - 1, 1'b0, fl, ld, {tag, "_above_out"});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    refr_tick = 1'b0;
    shoot     = 1'b0;
    vx_init   = 8'sd0;
    vy_init   = 8'sd0;
    pixel_x   = '0;
    pixel_y   = '0;
    probe_vld = 1'b0;
    repeat (2) step();
    reset = 1'b0;

    // Idle after reset
    probe(103, 400, 1'b1, 1'b0, 1'b0, "idle_103_400");
    probe(100, 402, 1'b1, 1'b0, 1'b0, "idle_100_402");
    probe(100, 400, 1'b0, 1'b0, 1'b0, "idle_corner");
    probe(108, 400, 1'b0, 1'b0, 1'b0, "idle_108_400");
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        probe(100 + c, 400 + r, rom_tb[r][7-c], 1'b0, 1'b0, $sformatf("rom_r%0d_c%0d", r, c));

    // Launch together with refr_tick: no movement on the launch edge
    vx_init = 8'sd3;  vy_init = -8'sd10;
    shoot = 1'b1; refr_tick = 1'b1;
    step();
    shoot = 1'b0; refr_tick = 1'b0;
    check_pos(100, 400, 1'b1, 1'b0, "launch");
    frame();
    check_pos(103, 390, 1'b1, 1'b0, "tick1");
    repeat (9) frame();
    check_pos(130, 345, 1'b1, 1'b0, "tick10");
    repeat (15) frame();
    check_pos(175, 450, 1'b1, 1'b0, "tick25");
    frame();
    check_pos(178, 464, 1'b0, 1'b1, "floor");
    repeat (59) frame();
    check_pos(178, 464, 1'b0, 1'b1, "hold59");
    frame();
    check_pos(100, 400, 1'b0, 1'b0, "hold_done");

    // Right wall clamp
    vx_init = 8'sd100; vy_init = -8'sd5;
    shoot = 1'b1;
    step();
    shoot = 1'b0;
    repeat (5) frame();
    check_pos(600, 385, 1'b1, 1'b0, "wall_t5");
    frame();
    check_pos(632, 385, 1'b0, 1'b1, "wall_right");
    repeat (60) frame();
    check_pos(100, 400, 1'b0, 1'b0, "wall_done");

    // Left wall clamp with shoot held through FLIGHT and LANDED
    vx_init = -8'sd128; vy_init = 8'sd0;
    shoot = 1'b1;
    step();
    check_pos(100, 400, 1'b1, 1'b0, "left_launch");
    frame();
    check_pos(0, 400, 1'b0, 1'b1, "wall_left");
    repeat (59) frame();
    check_pos(0, 400, 1'b0, 1'b1, "left_hold59");
    vx_init = 8'sd3; vy_init = -8'sd10;
    frame();
    probe(103, 400, 1'b1, 1'b0, 1'b0, "idle_first_cycle");
    check_pos(100, 400, 1'b1, 1'b0, "relaunch");
    shoot = 1'b0;

    // Reset mid-flight
    repeat (6) frame();
    check_pos(118, 355, 1'b1, 1'b0, "mid_flight");
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_pos(100, 400, 1'b0, 1'b0, "after_reset");

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
